// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU execution unit.
//   ALU_XLEN      : default datapath width
//   OP_*          : alu_op encodings {inst30, funct3}
//   alu_state_t   : execution FSM states (IDLE / SHIFT / DONE)
//   shift_kind_t  : shifter operation select
//   decode_shift  : maps an alu_op onto a shift kind (SH_NONE for non-shifts)
package alu_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        SH_SLL  = 2'd0,
        SH_SRL  = 2'd1,
        SH_SRA  = 2'd2,
        SH_NONE = 2'd3
    } shift_kind_t;

    function automatic shift_kind_t decode_shift(input logic [3:0] op);
        case (op)
            OP_SLL:  return SH_SLL;
            OP_SRL:  return SH_SRL;
            OP_SRA:  return SH_SRA;
            default: return SH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter -- combinational shifter datapath for alu_exec_unit.
//   kind      : SH_SLL / SH_SRL / SH_SRA (SH_NONE passes shift_in through)
//   shift_in  : value to shift
//   shamt     : shift amount (fast build) or remaining-step count (iterative)
//   shift_out : shifted value
// Build option ALU_EXEC_FAST_SHIFT_EN: when defined, a full barrel shift by
// shamt; otherwise a single one-bit step, taken only while shamt is nonzero.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  shift_kind_t     kind,
    input  logic [XLEN-1:0] shift_in,
    input  logic [4:0]      shamt,
    output logic [XLEN-1:0] shift_out
);

    always_comb begin
        shift_out = shift_in;
`ifdef ALU_EXEC_FAST_SHIFT_EN
        case (kind)
            SH_SLL:  shift_out = shift_in << shamt;
            SH_SRL:  shift_out = shift_in >> shamt;
            SH_SRA:  shift_out = $signed(shift_in) >>> shamt;
            default: shift_out = shift_in;
        endcase
`else
        if (shamt != 5'd0) begin
            case (kind)
                SH_SLL:  shift_out = {shift_in[XLEN-2:0], 1'b0};
                SH_SRL:  shift_out = {1'b0, shift_in[XLEN-1:1]};
                SH_SRA:  shift_out = {shift_in[XLEN-1], shift_in[XLEN-1:1]};
                default: shift_out = shift_in;
            endcase
        end
`endif
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- handshaked ALU execution unit (RV32I-style ops).
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operation handshake (alu_op, operand_a, operand_b)
//   out_valid / out_ready : result handshake (result, zero)
//   state_dbg             : current FSM state, for observation
// Build option ALU_EXEC_FAST_SHIFT_EN: barrel shifts, every op 1-cycle latency.
// Default build shifts one bit per cycle in state SHIFT (latency shamt+1).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready never depends on in_valid; out_valid never depends on
// out_ready. While out_valid=1 and out_ready=0, result and zero stay put.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output alu_state_t      state_dbg
);

    alu_state_t      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    shift_kind_t     op_kind;
    logic            is_shift;
    logic            accept;
    logic [XLEN-1:0] alu_val;
    logic [XLEN-1:0] shift_out;
`ifndef ALU_EXEC_FAST_SHIFT_EN
    logic [XLEN-1:0] hold_q, hold_d;
    logic [4:0]      cnt_q, cnt_d;
    shift_kind_t     kind_q, kind_d;
`endif

    assign op_kind  = decode_shift(alu_op);
    assign is_shift = (op_kind != SH_NONE);
    // rst_n gates in_ready so nothing is taken while reset is asserted.
    assign in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept   = in_valid && in_ready;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    alu_shifter #(.XLEN(XLEN)) u_shifter (
        .kind      (op_kind),
        .shift_in  (operand_a),
        .shamt     (operand_b[4:0]),
        .shift_out (shift_out)
    );
`else
    // Iterative: steps the held value while the remaining count is nonzero.
    alu_shifter #(.XLEN(XLEN)) u_shifter (
        .kind      (kind_q),
        .shift_in  (hold_q),
        .shamt     (cnt_q),
        .shift_out (shift_out)
    );
`endif

    always_comb begin
        alu_val = '0;
        case (alu_op)
            OP_ADD:  alu_val = operand_a + operand_b;
            OP_SUB:  alu_val = operand_a - operand_b;
            OP_SLT:  alu_val = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            OP_XOR:  alu_val = operand_a ^ operand_b;
            OP_OR:   alu_val = operand_a | operand_b;
            OP_AND:  alu_val = operand_a & operand_b;
`ifdef ALU_EXEC_FAST_SHIFT_EN
            OP_SLL, OP_SRL, OP_SRA: alu_val = shift_out;
`else
            // Only reached for shamt=0; nonzero shifts go through SHIFT.
            OP_SLL, OP_SRL, OP_SRA: alu_val = operand_a;
`endif
            default: alu_val = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifndef ALU_EXEC_FAST_SHIFT_EN
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // In DONE, accept implies out_ready: the old result retires
                // on the same edge that the new op is taken.
                if (accept) begin
`ifndef ALU_EXEC_FAST_SHIFT_EN
                    if (is_shift && (operand_b[4:0] != 5'd0)) begin
                        state_d = SHIFT;
                        hold_d  = operand_a;
                        cnt_d   = operand_b[4:0];
                        kind_d  = op_kind;
                    end else
`endif
                    begin
                        state_d  = DONE;
                        result_d = alu_val;
                        zero_d   = (alu_val == '0);
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
`ifndef ALU_EXEC_FAST_SHIFT_EN
                hold_d = shift_out;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d  = DONE;
                    result_d = shift_out;
                    zero_d   = (shift_out == '0);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            hold_q   <= '0;
            cnt_q    <= 5'd0;
            kind_q   <= SH_SLL;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
`endif
        end
    end

    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit -- self-checking bench for alu_exec_unit.
// A reference model (expected-result queue plus ready cycle) is compared
// against the DUT on every negative clock edge; directed cases pin the model
// with hand-computed literals, then randomized traffic with backpressure runs.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef ALU_EXEC_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    // ---------------- clock / reset / signals ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_op = 4'd0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    alu_state_t   state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit bp_en = 1'b0;
    bit or_dir = 1'b1;

    logic [W-1:0] exp_q[$];
    int           rdy_q[$];

    logic [3:0] op_tab [12] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
                                OP_SRL, OP_SRA, OP_OR, OP_AND, 4'b1111, 4'b1010};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // out_ready owner: random backpressure or the directed value.
    always @(posedge clk) begin
        #2;
        if (bp_en) out_ready = ($urandom_range(0, 9) < 7);
        else       out_ready = or_dir;
    end

    alu_exec_unit #(.XLEN(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .state_dbg (state_dbg)
    );

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << sh;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $signed(a) >>> sh;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [W-1:0] b);
        bit is_sh;
        is_sh = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
        if (is_sh && !FAST && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    bit           ev;
    bit           eir;
    logic [W-1:0] er;
    always @(negedge clk) begin
        ev  = (exp_q.size() > 0) && (cyc >= rdy_q[0]);
        eir = rst_n && ((exp_q.size() == 0) || (ev && out_ready));
        check("out_valid", 32'(out_valid), 32'(ev));
        check("in_ready", 32'(in_ready), 32'(eir));
        if (ev) begin
            er = exp_q[0];
            check("result", result, er);
            check("zero", 32'(zero), 32'(er == '0));
        end
        if (!rst_n) begin
            exp_q.delete();
            rdy_q.delete();
        end else begin
            if (ev && out_ready) begin
                void'(exp_q.pop_front());
                void'(rdy_q.pop_front());
            end
            if (in_valid && eir) begin
                exp_q.push_back(ref_result(alu_op, operand_a, operand_b));
                rdy_q.push_back(cyc + ref_latency(alu_op, operand_b));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge
    // with in_valid still high.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        alu_op = op;
        operand_a = a;
        operand_b = b;
        while (!got && waited < 200) begin
            @(negedge clk);
            got = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (!got) waited++;
        end
        check("accept_wait", 32'(got), 32'd1);
    endtask

    task automatic wait_result(input string name, input logic [W-1:0] exp_res, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 100);
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " result"}, result, exp_res);
        check({name, " zero"}, 32'(zero), 32'(exp_res == '0));
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res, input int exp_lat);
        int w;
        send(op, a, b, w);
        in_valid = 1'b0;
        wait_result(name, exp_res, exp_lat);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int cnt;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready during reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        check("reset zero", 32'(zero), 32'd1);
        check("reset state", 32'(state_dbg), 32'(IDLE));
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed cases with literal expectations
        run_op("add", OP_ADD, 32'd5, 32'd7, 32'd12, 1);
        run_op("sub", OP_SUB, 32'd3, 32'd3, 32'd0, 1);
        run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("sra31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, FAST ? 1 : 32);
        run_op("sll0", OP_SLL, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
        run_op("srl4", OP_SRL, 32'hF000_0000, 32'd4, 32'h0F00_0000, FAST ? 1 : 5);
        run_op("sll31", OP_SLL, 32'd1, 32'd31, 32'h8000_0000, FAST ? 1 : 32);
        run_op("undef", 4'b1111, 32'd9, 32'd9, 32'd0, 1);

        // Backpressure then back-to-back accept
        or_dir = 1'b0;
        send(OP_ADD, 32'd100, 32'd23, w);
        in_valid = 1'b0;
        wait_result("bp add", 32'd123, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp held result", result, 32'd123);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        or_dir = 1'b1;
        in_valid = 1'b1;
        alu_op = OP_XOR;
        operand_a = 32'hFF00_FF00;
        operand_b = 32'h0F0F_0F0F;
        @(negedge clk);
        check("b2b in_ready", 32'(in_ready), 32'd1);
        check("b2b old result", result, 32'd123);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b out_valid", 32'(out_valid), 32'd1);
        check("b2b result", result, 32'hF00F_F00F);
        @(posedge clk);
        #1;

        // Reset in the middle of an SRL by 20
        send(OP_SRL, 32'hDEAD_BEEF, 32'd20, w);
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort result", result, 32'd0);
        check("abort zero", 32'(zero), 32'd1);
        check("abort state", 32'(state_dbg), 32'(IDLE));
        check("abort in_ready", 32'(in_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) cnt++;
        end
        check("abort no late result", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = op_tab[$urandom_range(0, 11)];
            a = $urandom;
            if ($urandom_range(0, 1) == 1) b = $urandom;
            else b = W'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) b = a;
            send(op, a, b, w);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
        bp_en = 1'b0;
        or_dir = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous to clk, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream offers an operation this cycle.
REQ-005 SHALL have port in_ready  output  1  unit accepts the offered operation this cycle.
REQ-006 SHALL have port alu_op  input  4  operation code {inst30, funct3} from the ALU control decoder.
REQ-007 SHALL have port operand_a  input  XLEN  first source operand.
REQ-008 SHALL have port operand_b  input  XLEN  second source operand; bits [4:0] are the shift amount for shifts.
REQ-009 SHALL have port out_valid  output  1  result is valid.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-011 SHALL have port result  output  XLEN  operation result.
REQ-012 SHALL have port zero  output  1  high when result equals 0.

Function
REQ-013 SHALL accept an operation only on a cycle with in_valid=1 and in_ready=1, capturing alu_op, operand_a and operand_b.
REQ-014 SHALL decode alu_op as: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
REQ-015 SHALL produce result 0 for any other alu_op code, with normal latency and handshake.
REQ-016 SHALL wrap ADD/SUB modulo 2^XLEN; SLT/SLTU SHALL produce 1 or 0, zero-extended.
REQ-017 SHALL use FSM states IDLE, SHIFT, DONE: IDLE->DONE on accept of a non-shift op; IDLE->SHIFT on accept of a shift op with shamt>0; IDLE->DONE on accept of a shift op with shamt=0.
REQ-018 SHALL in SHIFT shift the held value one bit per cycle (SRA replicates the sign bit, SRL/SLL fill with zero), decrementing a 5-bit counter, and go SHIFT->DONE when the counter reaches 0.
REQ-019 SHALL assert out_valid exactly in DONE; latency from accept to out_valid is 1 cycle for non-shift ops and shamt+1 cycles for shifts.
REQ-020 SHALL hold result and zero stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive in_ready=1 in IDLE, and in DONE when out_ready=1; in SHIFT in_ready SHALL be 0.
REQ-022 SHALL, in DONE with out_ready=1 and in_valid=1, retire the current result and accept the new op in the same cycle (back-to-back, no bubble).
REQ-023 SHALL, in DONE with out_ready=1 and in_valid=0, return to IDLE.

Reset
REQ-024 SHALL, on a clk edge with rst_n=0, set state IDLE, out_valid=0, result=0, zero=1, and shift counter=0.
REQ-025 SHALL let reset abort an in-flight shift or pending result; no result SHALL be presented for it afterwards.
REQ-026 SHALL drive in_ready=0 in any cycle where rst_n=0.

Configuration
REQ-027 SHALL, with macro ALU_EXEC_FAST_SHIFT_EN defined, compute all shifts combinationally with a barrel shifter: state SHIFT unused, latency 1 cycle for every op.
REQ-028 SHALL, without ALU_EXEC_FAST_SHIFT_EN, use the iterative one-bit-per-cycle shifter of REQ-017/018; results SHALL be identical in both builds.

Structure
REQ-029 SHALL take alu_op encoding localparams, the FSM state typedef (IDLE/SHIFT/DONE) and the XLEN default from the shared package alu_pkg.
REQ-030 SHALL place the shifter datapath (iterative and fast variants, selected by the macro) in the sub-module alu_shifter.

Verification
REQ-031 SHALL verify ADD: a=5, b=7, op 0000 accepted at cycle N -> out_valid=1, result=12, zero=0 at N+1.
REQ-032 SHALL verify SUB and SLT/SLTU: SUB 3-3 -> result=0, zero=1; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-033 SHALL verify SRA: a=0x80000000, b=31 -> result=0xFFFFFFFF after 32 cycles (macro off) or 1 cycle (macro on); SLL with b=0 -> result=a after 1 cycle.
REQ-034 SHALL verify backpressure: out_ready=0 for 5 cycles -> result held, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept, next result 1 cycle later.
REQ-035 SHALL verify reset mid-shift: rst_n=0 for one cycle during an SRL by 20 -> out_valid=0, result=0, zero=1, state IDLE, in_ready=1 the cycle after release.
REQ-036 SHALL verify undefined op 1111 with a=9, b=9 -> result=0, zero=1 after 1 cycle.
